pixel_streamer: RTL

PIXEL_STREAMER -- requirements
Module: pixel_streamer

---
 rtl/pixel_streamer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pixel_streamer.sv
// pixel_streamer: fetches one image line from memory per VGA line trigger and
// streams it out as {R,G,B} pixels. The line base advances with an adder, so
// no row*H_SIZE multiply is needed.
// Handshake: there is no backpressure. mem_addr is issued each streaming cycle,
// mem_data is taken exactly one cycle later, and raw_rgb/pixel_valid follow one
// cycle after that.
module pixel_streamer #(
  parameter int H_SIZE  = 607,
  parameter int V_SIZE  = 455,
  parameter int X_OFSET = 290,
  parameter int Y_OFSET = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] hc,
  input  logic [10:0] vc,
  output logic [18:0] mem_addr,
  input  logic [17:0] mem_data,
  output logic        synch_pulse,
  output logic [17:0] raw_rgb,
  output logic        pixel_valid,
  output logic        frame_done,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    WAIT_LINE  = 2'd1,
    STREAM     = 2'd2,
    DONE       = 2'd3
  } state_t;

  localparam int COL_W = (H_SIZE > 2) ? $clog2(H_SIZE) : 1;
  localparam int ROW_W = $clog2(V_SIZE + 1);

  localparam logic [10:0]      TRIG_HC  = 11'(X_OFSET - 2);
  localparam logic [10:0]      Y_LO     = 11'(Y_OFSET);
  localparam logic [10:0]      Y_HI     = 11'(Y_OFSET + V_SIZE - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(H_SIZE - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(V_SIZE - 1);
  localparam logic [18:0]      H_STEP   = 19'(H_SIZE);

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [18:0]       base_q, base_d;
  logic [18:0]       addr_q, addr_d;
  logic              rd_v_q, rd_v_d;
  logic              synch_q, synch_d;
  logic [17:0]       raw_q, raw_d;
  logic              pv_q, pv_d;
  logic              done_p1_q, done_p1_d;
  logic              done_p2_q, done_p2_d;
  logic              fdone_q, fdone_d;

  logic frame_start;
  logic trigger;
  logic end_last;

  assign frame_start = (hc == 11'd0) && (vc == 11'd0);
  assign trigger     = (state_q == WAIT_LINE) && (hc == TRIG_HC) &&
                       (vc >= Y_LO) && (vc <= Y_HI);

  // Next-state, address generation and output pipeline computation
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    base_d   = base_q;
    addr_d   = addr_q;
    rd_v_d   = 1'b0;
    synch_d  = 1'b0;
    end_last = 1'b0;

    if (frame_start) begin
      // Frame start wins from any state and aborts an in-flight line.
      state_d = WAIT_LINE;
      col_d   = '0;
      row_d   = '0;
      base_d  = '0;
      addr_d  = '0;
    end else begin
      case (state_q)
        WAIT_LINE: begin
          if (trigger) begin
            // Trigger cycle issues pixel 0 (mem_addr already holds line base).
            rd_v_d  = 1'b1;
            synch_d = 1'b1;
            addr_d  = addr_q + 19'd1;
            col_d   = COL_W'(1);
            state_d = STREAM;
          end
        end
        STREAM: begin
          rd_v_d = 1'b1;
          if (col_q == LAST_COL) begin
            base_d = base_q + H_STEP;
            row_d  = row_q + ROW_W'(1);
            col_d  = '0;
            if (row_q == LAST_ROW) begin
              // Keep the final address so it never runs past the image.
              state_d  = DONE;
              end_last = 1'b1;
            end else begin
              // Preload the next base so it is on mem_addr at the next trigger.
              state_d = WAIT_LINE;
              addr_d  = base_q + H_STEP;
            end
          end else begin
            col_d  = col_q + COL_W'(1);
            addr_d = addr_q + 19'd1;
          end
        end
        default: ;
      endcase
    end

    pv_d      = rd_v_q && !frame_start;
    raw_d     = pv_d ? mem_data : 18'd0;
    done_p1_d = end_last;
    done_p2_d = done_p1_q && !frame_start;
    fdone_d   = done_p2_q && !frame_start;
  end

  // All state and outputs registered; synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= WAIT_FRAME;
      col_q     <= '0;
      row_q     <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      rd_v_q    <= 1'b0;
      synch_q   <= 1'b0;
      raw_q     <= '0;
      pv_q      <= 1'b0;
      done_p1_q <= 1'b0;
      done_p2_q <= 1'b0;
      fdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      base_q    <= base_d;
      addr_q    <= addr_d;
      rd_v_q    <= rd_v_d;
      synch_q   <= synch_d;
      raw_q     <= raw_d;
      pv_q      <= pv_d;
      done_p1_q <= done_p1_d;
      done_p2_q <= done_p2_d;
      fdone_q   <= fdone_d;
    end
  end

  assign mem_addr    = addr_q;
  assign synch_pulse = synch_q;
  assign raw_rgb     = raw_q;
  assign pixel_valid = pv_q;
  assign frame_done  = fdone_q;
  assign dbg_state   = state_q;

endmodule
